// File: rtl/decode_stage_if.sv
// ----------------------------------------------------------------------------
// decode_stage_if
//
// Purpose:
//   ID/EX bundle between the decode stage (producer) and the execute stage
//   (consumer). Every signal is driven from the decode stage's ID/EX
//   pipeline register, so the consumer always sees registered values.
//
// Signals:
//   control_out     [4:0]  {1'b0, opcode}; 5'b00000 marks a bubble (NOP)
//   dest_index_out  [4:0]  {2'b00, rd}
//   reg1_data       [15:0] operand 1
//   reg2_data       [15:0] operand 2
//   npc_out         [15:0] PC+1 of the decoded instruction
//   immediate       [6:0]  instr[6:0]
//
// Modports:
//   master  decode side, drives the bundle
//   slave   execute side, receives the bundle
// ----------------------------------------------------------------------------
interface decode_stage_if;
    logic [4:0]  control_out;
    logic [4:0]  dest_index_out;
    logic [15:0] reg1_data;
    logic [15:0] reg2_data;
    logic [15:0] npc_out;
    logic [6:0]  immediate;

    modport master (
        output control_out,
        output dest_index_out,
        output reg1_data,
        output reg2_data,
        output npc_out,
        output immediate
    );

    modport slave (
        input control_out,
        input dest_index_out,
        input reg1_data,
        input reg2_data,
        input npc_out,
        input immediate
    );
endinterface

// File: rtl/decode_stage.sv
// ----------------------------------------------------------------------------
// decode_stage
//
// Purpose:
//   Instruction-decode stage of the 16-bit pipelined core. Splits the fetched
//   instruction into fields, reads operands from an 8x16 register file with
//   a writeback port and same-cycle write-to-read bypass, detects load-use
//   hazards (stall fetch for one cycle and insert a bubble) and squashes the
//   held instruction on a taken branch. All execute-facing outputs come from
//   the ID/EX pipeline register.
//
// Parameters:
//   REG_COUNT      number of architectural registers (8, 3-bit fields)
//
// Ports:
//   clk            clock, rising edge
//   rst_n          synchronous active-low reset
//   instr          instruction from fetch
//   instr_valid    instr/npc_in are valid this cycle
//   npc_in         PC+1 of instr
//   branch_taken   execute resolved a taken jump; squash this stage
//   wb_en          register file write enable
//   wb_index       register file write address
//   wb_data        register file write data
//   stall          combinational; fetch holds instr/npc_in while high
//   ex             ID/EX bundle (decode_stage_if.master)
// ----------------------------------------------------------------------------
module decode_stage #(
    parameter int REG_COUNT = 8
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic [15:0]           instr,
    input  logic                  instr_valid,
    input  logic [15:0]           npc_in,
    input  logic                  branch_taken,
    input  logic                  wb_en,
    input  logic [2:0]            wb_index,
    input  logic [15:0]           wb_data,
    output logic                  stall,
    decode_stage_if.master        ex
);

    // Opcode map of the ISA (instr[15:12]).
    typedef enum logic [3:0] {
        OP_NOP    = 4'h0,
        OP_SUB    = 4'h1,
        OP_ADD    = 4'h2,
        OP_ADDI   = 4'h3,
        OP_SHLLI  = 4'h4,
        OP_SHRLI  = 4'h5,
        OP_JUMP   = 4'h6,
        OP_JUMPL  = 4'h7,
        OP_JUMPG  = 4'h8,
        OP_JUMPE  = 4'h9,
        OP_JUMPNE = 4'hA,
        OP_CMP    = 4'hB,
        OP_LOAD   = 4'hC,
        OP_LOADI  = 4'hD,
        OP_STORE  = 4'hE,
        OP_MOV    = 4'hF
    } opcode_t;

    // ------------------------------------------------------------------
    // Instruction fields
    // ------------------------------------------------------------------
    opcode_t     op;
    logic [2:0]  rd;
    logic [2:0]  rs;
    logic [2:0]  rt;
    logic [6:0]  imm;

    assign op  = opcode_t'(instr[15:12]);
    assign rd  = instr[11:9];
    assign rs  = instr[8:6];
    assign rt  = instr[5:3];
    assign imm = instr[6:0];

    // ------------------------------------------------------------------
    // Architectural state
    // ------------------------------------------------------------------
    logic [15:0] regfile [REG_COUNT];

    // The ID/EX register keeps only the meaningful bits; the zero-padded
    // upper bits of control and destination are added on the way out.
    opcode_t     op_q;
    logic [2:0]  rd_q;
    logic [15:0] reg1_q;
    logic [15:0] reg2_q;
    logic [15:0] npc_q;
    logic [6:0]  imm_q;

    // ------------------------------------------------------------------
    // Operand selection: which register feeds each read port, and whether
    // the port is used at all. An unused port yields a zero operand, and
    // an unused port must never trigger a load-use stall.
    // ------------------------------------------------------------------
    logic        rd1_en;
    logic        rd2_en;
    logic [2:0]  rd1_idx;
    logic [2:0]  rd2_idx;

    always_comb begin
        rd1_en  = 1'b0;
        rd2_en  = 1'b0;
        rd1_idx = rs;
        rd2_idx = rt;
        case (op)
            OP_SUB, OP_ADD, OP_CMP: begin
                rd1_en = 1'b1;
                rd2_en = 1'b1;
            end
            OP_ADDI, OP_SHLLI, OP_SHRLI: begin
                // Immediate ops work in place on rd.
                rd1_en  = 1'b1;
                rd1_idx = rd;
            end
            OP_MOV, OP_LOAD: begin
                rd1_en = 1'b1;
            end
            OP_STORE: begin
                // Port 1 carries the address base, port 2 the store data.
                rd1_en  = 1'b1;
                rd2_en  = 1'b1;
                rd2_idx = rd;
            end
            default: begin
                rd1_en = 1'b0;
                rd2_en = 1'b0;
            end
        endcase
    end

    // ------------------------------------------------------------------
    // Register file read ports. A write landing at the coming edge is
    // forwarded so the decoded operand already reflects it.
    // ------------------------------------------------------------------
    logic [15:0] rd1_raw;
    logic [15:0] rd2_raw;
    logic [15:0] operand1;
    logic [15:0] operand2;

    always_comb begin
        rd1_raw = regfile[rd1_idx];
        rd2_raw = regfile[rd2_idx];
        if (wb_en && (wb_index == rd1_idx)) begin
            rd1_raw = wb_data;
        end
        if (wb_en && (wb_index == rd2_idx)) begin
            rd2_raw = wb_data;
        end
        operand1 = rd1_en ? rd1_raw : 16'h0000;
        operand2 = rd2_en ? rd2_raw : 16'h0000;
    end

    // ------------------------------------------------------------------
    // Load-use hazard: the LOAD sitting in ID/EX has not produced its
    // value yet, so an incoming instruction reading its destination must
    // wait one cycle. The bubble inserted here removes the LOAD from
    // ID/EX, so the retry next cycle never stalls again.
    // A taken branch squashes the instruction anyway, so it never stalls.
    // No term depends on the writeback port.
    // ------------------------------------------------------------------
    logic load_use;

    always_comb begin
        load_use = 1'b0;
        if (op_q == OP_LOAD) begin
            load_use = (rd1_en && (rd1_idx == rd_q)) ||
                       (rd2_en && (rd2_idx == rd_q));
        end
        stall = rst_n && !branch_taken && instr_valid && load_use;
    end

    // ------------------------------------------------------------------
    // ID/EX pipeline register. Priority: reset, then flush, then hazard
    // stall, then an empty fetch slot; all of them leave a bubble.
    // ------------------------------------------------------------------
    logic insert_bubble;

    assign insert_bubble = branch_taken || stall || !instr_valid;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            op_q   <= OP_NOP;
            rd_q   <= 3'd0;
            reg1_q <= 16'h0000;
            reg2_q <= 16'h0000;
            npc_q  <= 16'h0000;
            imm_q  <= 7'd0;
        end else if (insert_bubble) begin
            op_q   <= OP_NOP;
            rd_q   <= 3'd0;
            reg1_q <= 16'h0000;
            reg2_q <= 16'h0000;
            npc_q  <= 16'h0000;
            imm_q  <= 7'd0;
        end else begin
            op_q   <= op;
            rd_q   <= rd;
            reg1_q <= operand1;
            reg2_q <= operand2;
            npc_q  <= npc_in;
            imm_q  <= imm;
        end
    end

    // ------------------------------------------------------------------
    // Register file write port. Writes commit independently of stalls and
    // flushes; only reset overrides them. R0 is an ordinary register.
    // ------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            for (int i = 0; i < REG_COUNT; i++) begin
                regfile[i] <= 16'h0000;
            end
        end else if (wb_en) begin
            regfile[wb_index] <= wb_data;
        end
    end

    // ------------------------------------------------------------------
    // Execute-facing bundle
    // ------------------------------------------------------------------
    assign ex.control_out    = {1'b0, op_q};
    assign ex.dest_index_out = {2'b00, rd_q};
    assign ex.reg1_data      = reg1_q;
    assign ex.reg2_data      = reg2_q;
    assign ex.npc_out        = npc_q;
    assign ex.immediate      = imm_q;

endmodule

// File: tb/tb_decode_stage.sv
// ----------------------------------------------------------------------------
// tb_decode_stage
//
// Purpose:
//   Self-checking bench for decode_stage. A table of directed vectors with
//   hand-derived expectations walks through reset, operand reads, bypass,
//   load-use stall, flush and reset-during-stall; a randomized phase then
//   compares every cycle against a behavioural model of the decode rules.
// ----------------------------------------------------------------------------
module tb_decode_stage;

    typedef struct packed {
        logic [4:0]  ctrl;
        logic [4:0]  dest;
        logic [15:0] r1;
        logic [15:0] r2;
        logic [15:0] npc;
        logic [6:0]  imm;
    } idex_t;

    typedef struct {
        logic        rstn;
        logic [15:0] instr;
        logic        valid;
        logic [15:0] npc;
        logic        br;
        logic        wen;
        logic [2:0]  widx;
        logic [15:0] wdata;
    } stim_t;

    typedef struct {
        stim_t s;
        logic  exp_stall;
        idex_t exp;
    } vec_t;

    logic        clk = 1'b0;
    logic        rst_n;
    logic [15:0] instr;
    logic        instr_valid;
    logic [15:0] npc_in;
    logic        branch_taken;
    logic        wb_en;
    logic [2:0]  wb_index;
    logic [15:0] wb_data;
    logic        stall;

    int checks = 0;
    int errors = 0;

    decode_stage_if ex_if ();

    decode_stage #(.REG_COUNT(8)) dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .instr        (instr),
        .instr_valid  (instr_valid),
        .npc_in       (npc_in),
        .branch_taken (branch_taken),
        .wb_en        (wb_en),
        .wb_index     (wb_index),
        .wb_data      (wb_data),
        .stall        (stall),
        .ex           (ex_if)
    );

    always #5 clk = ~clk;

    // Reference model state: register contents and the expected ID/EX view.
    logic [15:0] m_regs [8];
    idex_t       m_idex;

    // Operand source per opcode, straight from the ISA operand table:
    // 0 = not read, 1 = rs, 2 = rt, 3 = rd.
    int r1_sel [16];
    int r2_sel [16];

    vec_t vecs [$];

    function automatic int fieldOf(logic [15:0] ins, int sel);
        case (sel)
            1:       return int'(ins[8:6]);
            2:       return int'(ins[5:3]);
            3:       return int'(ins[11:9]);
            default: return 0;
        endcase
    endfunction

    task automatic addVec(input logic rstn, input logic [15:0] ins, input logic valid,
                          input logic [15:0] npc, input logic br, input logic wen,
                          input logic [2:0] widx, input logic [15:0] wdata,
                          input logic est, input logic [4:0] ectrl, input logic [4:0] edest,
                          input logic [15:0] er1, input logic [15:0] er2,
                          input logic [15:0] enpc, input logic [6:0] eimm);
        vec_t v;
        v.s.rstn  = rstn;
        v.s.instr = ins;
        v.s.valid = valid;
        v.s.npc   = npc;
        v.s.br    = br;
        v.s.wen   = wen;
        v.s.widx  = widx;
        v.s.wdata = wdata;
        v.exp_stall = est;
        v.exp.ctrl  = ectrl;
        v.exp.dest  = edest;
        v.exp.r1    = er1;
        v.exp.r2    = er2;
        v.exp.npc   = enpc;
        v.exp.imm   = eimm;
        vecs.push_back(v);
    endtask

    task automatic applyStimulus(input stim_t s);
        rst_n        = s.rstn;
        instr        = s.instr;
        instr_valid  = s.valid;
        npc_in       = s.npc;
        branch_taken = s.br;
        wb_en        = s.wen;
        wb_index     = s.widx;
        wb_data      = s.wdata;
    endtask

    task automatic checkOutput(input string name, input logic [15:0] act, input logic [15:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("[TB] FAIL %s: got %h, expected %h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // One clock cycle: drive, check stall before the edge, check ID/EX after.
    // The model always advances; expectations come from the table or model.
    task automatic runCycle(input stim_t s, input bit use_table, input logic tbl_stall,
                            input idex_t tbl_exp, input string tag);
        int    op, s1, s2, i1, i2;
        logic [15:0] v1, v2;
        logic  haz, m_stall;
        idex_t nxt;
        applyStimulus(s);
        #1;
        op = int'(s.instr[15:12]);
        s1 = r1_sel[op];
        s2 = r2_sel[op];
        i1 = fieldOf(s.instr, s1);
        i2 = fieldOf(s.instr, s2);
        v1 = 16'h0;
        v2 = 16'h0;
        if (s1 != 0) v1 = (s.wen && int'(s.widx) == i1) ? s.wdata : m_regs[i1];
        if (s2 != 0) v2 = (s.wen && int'(s.widx) == i2) ? s.wdata : m_regs[i2];
        haz = (m_idex.ctrl == 5'h0C) &&
              ((s1 != 0 && i1 == int'(m_idex.dest)) || (s2 != 0 && i2 == int'(m_idex.dest)));
        m_stall = s.rstn && !s.br && s.valid && haz;
        if (!s.rstn || s.br || m_stall || !s.valid) begin
            nxt = '0;
        end else begin
            nxt.ctrl = {1'b0, s.instr[15:12]};
            nxt.dest = {2'b00, s.instr[11:9]};
            nxt.r1   = v1;
            nxt.r2   = v2;
            nxt.npc  = s.npc;
            nxt.imm  = s.instr[6:0];
        end
        checkOutput({tag, " stall"}, 16'(stall), 16'(use_table ? tbl_stall : m_stall));
        @(posedge clk);
        #1;
        if (!s.rstn) begin
            for (int k = 0; k < 8; k++) m_regs[k] = 16'h0;
        end else if (s.wen) begin
            m_regs[s.widx] = s.wdata;
        end
        m_idex = nxt;
        if (use_table) nxt = tbl_exp;
        checkOutput({tag, " control_out"},    16'(ex_if.control_out),    16'(nxt.ctrl));
        checkOutput({tag, " dest_index_out"}, 16'(ex_if.dest_index_out), 16'(nxt.dest));
        checkOutput({tag, " reg1_data"},      ex_if.reg1_data,           nxt.r1);
        checkOutput({tag, " reg2_data"},      ex_if.reg2_data,           nxt.r2);
        checkOutput({tag, " npc_out"},        ex_if.npc_out,             nxt.npc);
        checkOutput({tag, " immediate"},      16'(ex_if.immediate),      16'(nxt.imm));
    endtask

    initial begin
        stim_t s;
        idex_t dummy;

        r1_sel = '{0, 1, 1, 3, 3, 3, 0, 0, 0, 0, 0, 1, 1, 0, 1, 1};
        r2_sel = '{0, 2, 2, 0, 0, 0, 0, 0, 0, 0, 0, 2, 0, 0, 3, 0};
        for (int k = 0; k < 8; k++) m_regs[k] = 16'h0;
        m_idex = '0;
        dummy  = '0;

        //     rstn instr    vld npc      br wen idx wdata  | stall ctrl   dest   r1       r2       npc      imm
        // Reset (wins over writeback and flush), then R0..R7 read as zero.
        addVec(0, 16'h2458, 1, 16'h0011, 0, 1, 1, 16'h0099, 0, 5'h00, 5'd0, 16'h0000, 16'h0000, 16'h0000, 7'h00);
        addVec(0, 16'hC640, 1, 16'h0012, 1, 0, 0, 16'h0000, 0, 5'h00, 5'd0, 16'h0000, 16'h0000, 16'h0000, 7'h00);
        addVec(1, 16'h2008, 1, 16'h0001, 0, 0, 0, 16'h0000, 0, 5'h02, 5'd0, 16'h0000, 16'h0000, 16'h0001, 7'h08);
        addVec(1, 16'h2098, 1, 16'h0002, 0, 0, 0, 16'h0000, 0, 5'h02, 5'd0, 16'h0000, 16'h0000, 16'h0002, 7'h18);
        addVec(1, 16'h2128, 1, 16'h0003, 0, 0, 0, 16'h0000, 0, 5'h02, 5'd0, 16'h0000, 16'h0000, 16'h0003, 7'h28);
        addVec(1, 16'h21B8, 1, 16'h0004, 0, 0, 0, 16'h0000, 0, 5'h02, 5'd0, 16'h0000, 16'h0000, 16'h0004, 7'h38);
        // Preload R1=10, R3=5 with empty fetch slots, then ADD R2,R1,R3.
        addVec(1, 16'h0000, 0, 16'h0000, 0, 1, 1, 16'h000A, 0, 5'h00, 5'd0, 16'h0000, 16'h0000, 16'h0000, 7'h00);
        addVec(1, 16'h0000, 0, 16'h0000, 0, 1, 3, 16'h0005, 0, 5'h00, 5'd0, 16'h0000, 16'h0000, 16'h0000, 7'h00);
        addVec(1, 16'h2458, 1, 16'h0020, 0, 0, 0, 16'h0000, 0, 5'h02, 5'd2, 16'h000A, 16'h0005, 16'h0020, 7'h58);
        // R2=10, then ADDI R2,#7.
        addVec(1, 16'h0000, 0, 16'h0000, 0, 1, 2, 16'h000A, 0, 5'h00, 5'd0, 16'h0000, 16'h0000, 16'h0000, 7'h00);
        addVec(1, 16'h3407, 1, 16'h0021, 0, 0, 0, 16'h0000, 0, 5'h03, 5'd2, 16'h000A, 16'h0000, 16'h0021, 7'h07);
        // Bypass: SUB R1,R4,R4 while R4 <= 0x1234.
        addVec(1, 16'h1320, 1, 16'h0022, 0, 1, 4, 16'h1234, 0, 5'h01, 5'd1, 16'h1234, 16'h1234, 16'h0022, 7'h20);
        // Load-use: LOAD R3,[R1]; ADD R5,R3,R2 stalls (writeback R7 still commits), then retries.
        addVec(1, 16'hC640, 1, 16'h0023, 0, 0, 0, 16'h0000, 0, 5'h0C, 5'd3, 16'h000A, 16'h0000, 16'h0023, 7'h40);
        addVec(1, 16'h2AD0, 1, 16'h0024, 0, 1, 7, 16'h0077, 1, 5'h00, 5'd0, 16'h0000, 16'h0000, 16'h0000, 7'h00);
        addVec(1, 16'h2AD0, 1, 16'h0024, 0, 0, 0, 16'h0000, 0, 5'h02, 5'd5, 16'h0005, 16'h000A, 16'h0024, 7'h50);
        addVec(1, 16'h21B8, 1, 16'h0025, 0, 0, 0, 16'h0000, 0, 5'h02, 5'd0, 16'h0000, 16'h0077, 16'h0025, 7'h38);
        // Flush of a plain ADD, then flush of an ADD with a pending hazard.
        addVec(1, 16'h2458, 1, 16'h0026, 1, 0, 0, 16'h0000, 0, 5'h00, 5'd0, 16'h0000, 16'h0000, 16'h0000, 7'h00);
        addVec(1, 16'hC640, 1, 16'h0030, 0, 0, 0, 16'h0000, 0, 5'h0C, 5'd3, 16'h000A, 16'h0000, 16'h0030, 7'h40);
        addVec(1, 16'h2AD0, 1, 16'h0031, 1, 0, 0, 16'h0000, 0, 5'h00, 5'd0, 16'h0000, 16'h0000, 16'h0000, 7'h00);
        addVec(1, 16'h2AD0, 1, 16'h0031, 0, 0, 0, 16'h0000, 0, 5'h02, 5'd5, 16'h0005, 16'h000A, 16'h0031, 7'h50);
        // After LOAD: a jump naming R3 only in its rd field, and an invalid reader, do not stall.
        addVec(1, 16'hC640, 1, 16'h0040, 0, 0, 0, 16'h0000, 0, 5'h0C, 5'd3, 16'h000A, 16'h0000, 16'h0040, 7'h40);
        addVec(1, 16'h6600, 1, 16'h0041, 0, 0, 0, 16'h0000, 0, 5'h06, 5'd3, 16'h0000, 16'h0000, 16'h0041, 7'h00);
        addVec(1, 16'hC640, 1, 16'h0042, 0, 0, 0, 16'h0000, 0, 5'h0C, 5'd3, 16'h000A, 16'h0000, 16'h0042, 7'h40);
        addVec(1, 16'h2AD0, 0, 16'h0043, 0, 0, 0, 16'h0000, 0, 5'h00, 5'd0, 16'h0000, 16'h0000, 16'h0000, 7'h00);
        // STORE R3,[R1]: address from rs, data from rd.
        addVec(1, 16'hE640, 1, 16'h0044, 0, 0, 0, 16'h0000, 0, 5'h0E, 5'd3, 16'h000A, 16'h0005, 16'h0044, 7'h40);
        // Reset wins over a pending stall and clears the register file.
        addVec(1, 16'hC640, 1, 16'h0050, 0, 0, 0, 16'h0000, 0, 5'h0C, 5'd3, 16'h000A, 16'h0000, 16'h0050, 7'h40);
        addVec(0, 16'h2AD0, 1, 16'h0051, 0, 0, 0, 16'h0000, 0, 5'h00, 5'd0, 16'h0000, 16'h0000, 16'h0000, 7'h00);
        addVec(1, 16'h2458, 1, 16'h0052, 0, 0, 0, 16'h0000, 0, 5'h02, 5'd2, 16'h0000, 16'h0000, 16'h0052, 7'h58);

        $display("[TB] directed vectors: %0d", vecs.size());
        for (int i = 0; i < vecs.size(); i++) begin
            runCycle(vecs[i].s, 1'b1, vecs[i].exp_stall, vecs[i].exp, $sformatf("vec%0d", i));
        end

        $display("[TB] randomized phase");
        for (int n = 0; n < 400; n++) begin
            s.rstn  = ($urandom_range(0, 49) != 0);
            s.instr = 16'($urandom);
            if ($urandom_range(0, 3) == 0) s.instr[15:12] = 4'hC;
            s.valid = ($urandom_range(0, 9) != 0);
            s.npc   = 16'($urandom);
            s.br    = ($urandom_range(0, 9) == 0);
            s.wen   = ($urandom_range(0, 1) == 1);
            s.widx  = 3'($urandom_range(0, 7));
            s.wdata = 16'($urandom);
            runCycle(s, 1'b0, 1'b0, dummy, $sformatf("rnd%0d", n));
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
